// File: rtl/ctrl_decode_q.sv
// ctrl_decode_q: RV32I/RV32M control decoder feeding a valid/ready FIFO of decoded bundles
module ctrl_decode_q #(
    parameter bit EN_M  = 1'b1,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [4:0]       alu_ctrl,
    output logic [1:0]       whb,
    output logic             su,
    output logic [1:0]       wos,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [4:0] ADD = 5'b00000, SUB = 5'b00001, AND = 5'b00010, OR = 5'b00100,
                           XOR = 5'b01000, SRL = 5'b01001, SLL = 5'b01010, SRA = 5'b01100,
                           PASSB = 5'b01101;
    typedef struct packed {
        logic [31:0] instr;
        logic [4:0]  alu;
        logic [1:0]  whb;
        logic        su;
        logic [1:0]  wos;
        logic        bad;
    } bundle_t;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [4:0] alu, base;
    logic [1:0] dwhb, dwos;
    logic       dsu, bad, push, pop;
    logic [AW:0] count;
    logic [AW-1:0] wr_ptr, rd_ptr;
    bundle_t mem [DEPTH];
    bundle_t head;
    assign op = instr[6:0];
    assign f3 = instr[14:12];
    assign f7 = instr[31:25];
    always_comb begin
        base = f3 == 3'b000 ? ADD : f3 == 3'b001 ? SLL : f3[2:1] == 2'b01 ? SUB :
               f3 == 3'b100 ? XOR : f3 == 3'b101 ? SRL : f3 == 3'b110 ? OR : AND;
        alu = ADD;
        dwhb = 2'b10;
        dsu = 1'b1;
        dwos = 2'b01;
        bad = 1'b0;
        case (op)
            7'b0110011: begin
                if (f7 == 7'b0000001) begin
                    alu = {2'b10, f3};
                    bad = !EN_M;
                end else if (f7 == 7'b0100000) begin
                    alu = f3 == 3'b000 ? SUB : SRA;
                    bad = f3 != 3'b000 && f3 != 3'b101;
                end else begin
                    alu = base;
                    dsu = f3 != 3'b011;
                    dwos = f3[2:1] == 2'b01 ? 2'b00 : 2'b01;
                    bad = f7 != 7'b0000000;
                end
            end
            7'b0010011: begin
                alu = (f3 == 3'b101 && f7[5]) ? SRA : base;
                dsu = f3 != 3'b011;
                dwos = f3[2:1] == 2'b01 ? 2'b00 : 2'b01;
                bad = (f3 == 3'b001 && f7 != 7'b0000000) ||
                      (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000);
            end
            7'b0000011: begin
                dwhb = f3[1:0];
                dsu = !f3[2];
                bad = f3[1:0] == 2'b11 || f3[2:1] == 2'b11;
            end
            7'b0100011: begin
                dwhb = f3[1:0];
                bad = f3[2] || f3[1:0] == 2'b11;
            end
            7'b1100011: begin
                alu = SUB;
                dsu = !(f3[2] && f3[1]);
                bad = f3[2:1] == 2'b01;
            end
            7'b1101111: dwos = 2'b10;
            7'b1100111: begin
                dwos = 2'b10;
                bad = f3 != 3'b000;
            end
            7'b0110111: alu = PASSB;
            7'b0010111: alu = ADD;
            default: bad = 1'b1;
        endcase
        if (bad) {alu, dwhb, dsu, dwos} = '0;
    end
    assign in_ready = count != CW'(DEPTH);
    assign out_valid = count != '0;
    assign push = in_valid & in_ready & ~flush;
    assign pop = out_valid & out_ready;
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            count <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            count <= count + CW'(push) - CW'(pop);
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) illegal_cnt <= '0;
        else if (push && bad && illegal_cnt != '1) illegal_cnt <= illegal_cnt + 1'b1;
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{instr, alu, dwhb, dsu, dwos, bad};
    end
    // An empty queue presents an all-zero bundle rather than stale storage.
    assign head = out_valid ? mem[rd_ptr] : '0;
    assign {out_instr, alu_ctrl, whb, su, wos, illegal} = head;
endmodule

// File: doc/ctrl_decode_q.md
Name: ctrl_decode_q

Overview:
- Registered, parametrised successor to the combinational control decoder.
- Decodes RV32I instructions, plus optional RV32M when EN_M=1, into the ALU/memory/writeback control bundle.
- Queues decoded bundles in a small FIFO behind a valid/ready handshake, so fetch and execute can stall independently.
- Flags illegal encodings deterministically (never X) and keeps a saturating illegal-instruction counter. Sits between fetch and execute in the pipelined core.

Parameters:
EN_M, 1, 1 = decode RV32M ops; 0 = RV32M encodings are illegal
DEPTH, 2, FIFO entries; power of 2, >=2
CNT_W, 16, width of the illegal-instruction counter

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  instr is valid
in_ready  out  1  block can accept instr this cycle
instr  in  32  instruction word
flush  in  1  discard all queued entries
out_valid  out  1  head bundle is valid
out_ready  in  1  consumer takes the head this cycle
out_instr  out  32  instruction word of the head entry
alu_ctrl  out  5  ALU operation
whb  out  2  access size: 00 byte, 01 half, 10 word
su  out  1  1 = signed, 0 = unsigned
wos  out  2  writeback select: 00 set-less result, 01 ALU result, 10 PC+4
illegal  out  1  head entry is an illegal instruction
illegal_cnt  out  CNT_W  saturating count of illegal instructions accepted

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low, on rst_n.
- Reset state:
  - count=0, read/write pointers=0, illegal_cnt=0.
  - out_valid=0, in_ready=1.
  - out_instr, alu_ctrl, whb, su, wos, illegal all 0.
- Decode: combinational on instr at push time. The bundle {instr, alu_ctrl, whb, su, wos, illegal} is stored in the FIFO.
- alu_ctrl codes (5 bits; bit4=1 only for RV32M):
  - ADD 00000, SUB 00001, AND 00010, OR 00100, XOR 01000, SRL 01001, SLL 01010, SRA 01100, PASSB 01101.
  - MUL 10000, MULH 10001, MULHSU 10010, MULHU 10011, DIV 10100, DIVU 10101, REM 10110, REMU 10111.
- R and I-ALU ops:
  - ADD/SUB/logic/shifts: whb=10, su=1, wos=01.
  - SLT/SLTI: alu_ctrl=SUB, wos=00, su=1.
  - SLTU/SLTIU: alu_ctrl=SUB, wos=00, su=0. This is a fix over the previous decoder, which drove su=1.
  - Shift-immediates require funct7 = 0000000, or 0100000 for SRAI; any other funct7 is illegal.
- Loads (LB/LH/LW/LBU/LHU) and stores (SB/SH/SW): alu_ctrl=ADD, wos=01, whb per size, su=0 only for LBU/LHU.
- Branches: alu_ctrl=SUB, whb=10, wos=01. su=0 for BLTU/BGEU, else 1. funct3 010 and 011 are illegal.
- Jumps and upper-immediates:
  - JAL, and JALR with funct3=000: alu_ctrl=ADD, whb=10, su=1, wos=10.
  - LUI: PASSB, wos=01. AUIPC: ADD, wos=01.
- RV32M: opcode 0110011 with funct7=0000001 decodes to the codes above when EN_M=1. When EN_M=0 these encodings are illegal.
- Illegal instructions: any unlisted opcode/funct combination.
  - Bundle: illegal=1, alu_ctrl=0, whb=0, su=0, wos=0; instr is still stored.
- Handshake:
  - push = in_valid & in_ready & ~flush.
  - pop = out_valid & out_ready.
  - in_ready = (count != DEPTH), driven from registered state. There is no combinational path from out_ready to in_ready, so a full FIFO refuses input even when popping that cycle.
  - out_valid = (count != 0).
- Latency: an instruction pushed at edge N is visible on the outputs after edge N, if the FIFO was empty. Order is strictly FIFO.
- Output hold: while out_valid=1 and out_ready=0, all outputs hold stable. When empty, all bundle outputs read 0.
- Simultaneous push and pop (not full, not empty): count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- flush: on the next edge count=0, pointers=0, out_valid=0. Flush beats a same-cycle push and pop. illegal_cnt is not cleared.
- illegal_cnt:
  - Increments on each push with illegal=1.
  - Saturates at 2^CNT_W-1.
  - Cleared only by reset.
- Reset mid-operation: all queued entries are dropped and every output returns to its reset value on that edge.

Test Plan:
- add x1,x2,x3 (0x003100B3) pushed with out_ready=1 -> next cycle out_valid=1, alu_ctrl=00000, whb=10, su=1, wos=01, illegal=0; one cycle later out_valid=0.
- lhu x1,0(x2) (0x00015083), then sltu x1,x2,x3 (0x003130B3):
  - lhu -> alu_ctrl=00000, whb=01, su=0, wos=01.
  - sltu -> alu_ctrl=00001, su=0, wos=00.
- mul x1,x2,x3 (0x023100B3):
  - EN_M=1 -> alu_ctrl=10000, illegal=0.
  - EN_M=0 -> illegal=1, bundle fields 0, illegal_cnt 0->1.
- DEPTH=2, out_ready=0, three back-to-back pushes A, B, C:
  - in_ready=0 after 2 pushes; C is held upstream.
  - Raise out_ready -> A then B on consecutive cycles; C is accepted once count<2 and appears after B.
- CNT_W=2, push 0xFFFFFFFF five times -> illegal=1 each time; illegal_cnt goes 1,2,3,3,3.
- Full FIFO with flush=1 and in_valid=1 in the same cycle -> next cycle out_valid=0, in_ready=1, nothing pushed, illegal_cnt unchanged.
- rst_n=0 for one edge while full -> all outputs at reset values.
